// File: rtl/unscale2.sv
// unscale2: removes a signed fixed-point scale factor from two channels at once.
// out = (in << fractionBits) / scale, computed by sequential restoring division
// on magnitudes (one quotient bit per clock), then sign-applied and saturated.
// A single controller runs both channels in lock-step with a fixed latency.
module unscale2 #(
    parameter  int integerBits  = 6,
    parameter  int fractionBits = 25,
    localparam int totalBits    = 1 + integerBits + fractionBits
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [totalBits-1:0] xIn,
    input  logic [totalBits-1:0] yIn,
    input  logic [totalBits-1:0] xScale,
    input  logic [totalBits-1:0] yScale,
    output logic [totalBits-1:0] xOut,
    output logic [totalBits-1:0] yOut,
    output logic                 xOvf,
    output logic                 yOvf,
    output logic                 outValid,
    input  logic                 outReady
);

    // Dividend is the numerator magnitude shifted up by the fraction width.
    localparam int N  = totalBits + fractionBits;
    localparam int CW = $clog2(N + 1);

    typedef logic [totalBits-1:0] word_t;   // signed operand / result word
    typedef logic [totalBits:0]   mag_t;    // magnitude with room for |most-negative|
    typedef logic [N-1:0]         quo_t;    // dividend shifting out, quotient shifting in

    localparam word_t MAX_POS = {1'b0, {(totalBits-1){1'b1}}};
    localparam word_t MIN_NEG = {1'b1, {(totalBits-1){1'b0}}};
    localparam quo_t  POS_LIM = quo_t'(MAX_POS);
    localparam quo_t  NEG_LIM = quo_t'(MIN_NEG);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, DONE} state_t;

    // Per-channel divider working set.
    typedef struct packed {
        mag_t  dvs;      // divisor magnitude
        word_t rem;      // partial remainder, always below the divisor
        quo_t  quo;      // dividend bits (MSB side) / quotient bits (LSB side)
        logic  neg;      // result is negative: operand signs differ
        logic  num_neg;  // numerator sign, selects the divide-by-zero limit
        logic  zero;     // scale was zero
    } chan_t;

    typedef struct packed {
        word_t val;
        logic  ovf;
    } res_t;

    // Two's-complement magnitude widened by one bit so the most-negative value
    // does not wrap back onto itself.
    function automatic mag_t magnitude(input word_t v);
        mag_t ext;
        ext = {v[totalBits-1], v};
        return ext[totalBits] ? mag_t'(-ext) : ext;
    endfunction

    function automatic chan_t load(input word_t num, input word_t den);
        chan_t c;
        c.dvs     = magnitude(den);
        c.rem     = '0;
        c.quo     = quo_t'(magnitude(num)) << fractionBits;
        c.neg     = num[totalBits-1] ^ den[totalBits-1];
        c.num_neg = num[totalBits-1];
        c.zero    = (den == '0);
        return c;
    endfunction

    // One restoring-division iteration: bring down the next dividend bit,
    // subtract the divisor if it fits, shift the resulting quotient bit in.
    function automatic chan_t step(input chan_t c);
        chan_t n;
        mag_t  sh;
        logic  ge;
        n     = c;
        sh    = {c.rem, c.quo[N-1]};
        ge    = (sh >= c.dvs);
        n.rem = ge ? word_t'(sh - c.dvs) : word_t'(sh);
        n.quo = {c.quo[N-2:0], ge};
        return n;
    endfunction

    // Apply sign and clamp the truncated quotient to the output range.
    function automatic res_t finish(input chan_t c);
        res_t r;
        if (c.zero) begin
            r.val = c.num_neg ? MIN_NEG : MAX_POS;
            r.ovf = 1'b1;
        end else if (!c.neg) begin
            r.ovf = (c.quo > POS_LIM);
            r.val = r.ovf ? MAX_POS : c.quo[totalBits-1:0];
        end else begin
            // A magnitude of exactly 2^(totalBits-1) negates onto MIN_NEG.
            r.ovf = (c.quo > NEG_LIM);
            r.val = r.ovf ? MIN_NEG : word_t'(-c.quo[totalBits-1:0]);
        end
        return r;
    endfunction

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    chan_t          x_q, y_q;
    chan_t          x_d, y_d;
    res_t           x_res, y_res;
    word_t          x_out_q, y_out_q;
    logic           x_ovf_q, y_ovf_q;
    logic           out_valid_q;

    // Next iteration of both dividers and the finished results, from current state.
    always_comb begin
        x_d   = step(x_q);
        y_d   = step(y_q);
        x_res = finish(x_q);
        y_res = finish(y_q);
    end

    // Controller and datapath registers: accept, iterate N times, finish, hand off.
    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: divider working registers are left unreset; they are always
            // reloaded on accept before anything reads them.
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inValid) begin
                        x_q     <= load(xIn, xScale);
                        y_q     <= load(yIn, yScale);
                        cnt_q   <= '0;
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    x_out_q     <= x_res.val;
                    x_ovf_q     <= x_res.ovf;
                    y_out_q     <= y_res.val;
                    y_ovf_q     <= y_res.ovf;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (outReady) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inReady  = (state_q == IDLE);
    assign xOut     = x_out_q;
    assign yOut     = y_out_q;
    assign xOvf     = x_ovf_q;
    assign yOvf     = y_ovf_q;
    assign outValid = out_valid_q;

endmodule

// File: tb/tb_unscale2.sv
// tb_unscale2: directed vector table, handshake/reset sequences and random
// operands checked against an arithmetic model of saturating division.
module tb_unscale2;

    localparam int F   = 25;
    localparam int LAT = 58;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] xIn, yIn, xScale, yScale;
    logic [31:0] xOut, yOut;
    logic        xOvf, yOvf;
    logic        outValid;
    logic        outReady;

    int n_checks = 0;
    int n_errors = 0;

    unscale2 #(.integerBits(6), .fractionBits(25)) dut (
        .clk     (clk),
        .reset   (reset),
        .inValid (inValid),
        .inReady (inReady),
        .xIn     (xIn),
        .yIn     (yIn),
        .xScale  (xScale),
        .yScale  (yScale),
        .xOut    (xOut),
        .yOut    (yOut),
        .xOvf    (xOvf),
        .yOvf    (yOvf),
        .outValid(outValid),
        .outReady(outReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: (num * 2^F) / den with truncation toward zero, then clamp.
    function automatic void ref_div(input logic [31:0] num, input logic [31:0] den,
                                    output logic [31:0] q, output logic ovf);
        longint n, d, r;
        n = longint'($signed(num));
        d = longint'($signed(den));
        if (d == 0) begin
            q   = (n >= 0) ? 32'h7FFFFFFF : 32'h80000000;
            ovf = 1'b1;
        end else begin
            r = (n * (longint'(1) << F)) / d;
            if (r > 64'sd2147483647) begin
                q = 32'h7FFFFFFF; ovf = 1'b1;
            end else if (r < -64'sd2147483648) begin
                q = 32'h80000000; ovf = 1'b1;
            end else begin
                q = r[31:0]; ovf = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h02000000;
            default: return 32'($signed(v) >>> $urandom_range(0, 31));
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Counts edges after an accept edge until outValid is seen (-1 on timeout).
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (outValid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Present one operand set, accept it, scramble inputs during the divide.
    task automatic run_op(input logic [31:0] xi, input logic [31:0] yi,
                          input logic [31:0] xs, input logic [31:0] ys,
                          output logic [31:0] xo, output logic [31:0] yo,
                          output logic xv, output logic yv, output int lat);
        @(negedge clk);
        xIn = xi; yIn = yi; xScale = xs; yScale = ys;
        inValid = 1'b1;
        check("ready_before_accept", inReady, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        xIn = $urandom; yIn = $urandom; xScale = $urandom; yScale = $urandom;
        wait_valid(lat);
        xo = xOut; yo = yOut; xv = xOvf; yv = yOvf;
    endtask

    task automatic release_result();
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check("consumed_valid_low", outValid, 0);
        check("consumed_ready_high", inReady, 1);
    endtask

    typedef struct {
        logic [31:0] x_in, y_in, x_sc, y_sc;
        logic [31:0] x_exp, y_exp;
        logic        xv_exp, yv_exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] xo, yo, qx, qy, hx, hy;
    logic        xv, yv, ox, oy;
    int          lat, seen;

    initial begin
        vecs.push_back('{32'h06000000, 32'hFA000000, 32'h03000000, 32'h04000000,
                         32'h04000000, 32'hFD000000, 1'b0, 1'b0});
        vecs.push_back('{32'h78000000, 32'h80000000, 32'h01000000, 32'hFE000000,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{32'hFC000000, 32'h00000000, 32'h00000000, 32'h00000000,
                         32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{32'h02000000, 32'h80000000, 32'h02000000, 32'h80000000,
                         32'h02000000, 32'h02000000, 1'b0, 1'b0});
        vecs.push_back('{32'h00000000, 32'h80000000, 32'hFE000000, 32'h02000000,
                         32'h00000000, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000003,
                         32'h00000000, 32'hFF555556, 1'b0, 1'b0});
        vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 32'h01000000, 32'hFE000000,
                         32'h80000000, 32'h80000001, 1'b1, 1'b0});

        reset = 1'b1; inValid = 1'b0; outReady = 1'b0;
        xIn = '0; yIn = '0; xScale = '0; yScale = '0;
        do_reset();

        @(negedge clk);
        check("rst_in_ready", inReady, 1);
        check("rst_out_valid", outValid, 0);
        check("rst_outputs", {xOut, yOut}, 64'h0);
        check("rst_flags", {xOvf, yOvf}, 0);

        // outReady while nothing is pending changes nothing.
        outReady = 1'b1;
        @(posedge clk);
        #1 outReady = 1'b0;
        check("idle_outready_valid", outValid, 0);
        check("idle_outready_ready", inReady, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].x_in, vecs[i].y_in, vecs[i].x_sc, vecs[i].y_sc, xo, yo, xv, yv, lat);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_xOut", i), xo, vecs[i].x_exp);
            check($sformatf("vec%0d_yOut", i), yo, vecs[i].y_exp);
            check($sformatf("vec%0d_flags", i), {xv, yv}, {vecs[i].xv_exp, vecs[i].yv_exp});
            release_result();
        end

        // Back-pressure: hold result 10 cycles while offering new operands.
        run_op(32'h06000000, 32'hFA000000, 32'h03000000, 32'h04000000, hx, hy, xv, yv, lat);
        check("bp_latency", lat, LAT);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            inValid = 1'b1;
            xIn = $urandom; yIn = $urandom; xScale = $urandom; yScale = $urandom;
            check("bp_hold_out", {xOut, yOut}, {32'h04000000, 32'hFD000000});
            check("bp_hold_ctl", {outValid, inReady, xOvf, yOvf}, 4'b1000);
        end
        // Consume while a second operand set is already waiting.
        @(negedge clk);
        xIn = 32'h02000000; yIn = 32'hFE000000; xScale = 32'h00800000; yScale = 32'h02000000;
        inValid = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1 outReady = 1'b0;
        check("bp_consume_valid", outValid, 0);
        check("bp_consume_ready", inReady, 1);
        @(posedge clk);
        #1 inValid = 1'b0;
        check("bp_second_accepted", inReady, 0);
        wait_valid(lat);
        check("bp_second_latency", lat, LAT);
        check("bp_second_out", {xOut, yOut}, {32'h08000000, 32'hFE000000});
        check("bp_second_flags", {xOvf, yOvf}, 0);
        release_result();

        // Reset during the divide discards the operation.
        @(negedge clk);
        xIn = 32'h06000000; yIn = 32'hFA000000; xScale = 32'h03000000; yScale = 32'h04000000;
        inValid = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_outputs", {xOut, yOut}, 64'h0);
        check("midrst_ctl", {outValid, inReady, xOvf, yOvf}, 4'b0100);
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1 if (outValid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        run_op(32'h06000000, 32'hFA000000, 32'h03000000, 32'h04000000, xo, yo, xv, yv, lat);
        check("postrst_latency", lat, LAT);
        check("postrst_out", {xo, yo}, {32'h04000000, 32'hFD000000});
        check("postrst_flags", {xv, yv}, 0);

        // Reset while the result is pending in DONE.
        do_reset();
        check("donerst_outputs", {xOut, yOut}, 64'h0);
        check("donerst_ctl", {outValid, inReady, xOvf, yOvf}, 4'b0100);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b, c, d;
            a = rand_word(); b = rand_word(); c = rand_word(); d = rand_word();
            ref_div(a, c, qx, ox);
            ref_div(b, d, qy, oy);
            run_op(a, b, c, d, xo, yo, xv, yv, lat);
            check($sformatf("rnd%0d_latency", i), lat, LAT);
            check($sformatf("rnd%0d_x %h/%h", i, a, c), {xo, 31'b0, xv}, {qx, 31'b0, ox});
            check($sformatf("rnd%0d_y %h/%h", i, b, d), {yo, 31'b0, yv}, {qy, 31'b0, oy});
            release_result();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
